// File: rtl/rv_trap_ctrl.sv
// rv_trap_ctrl: machine-mode trap entry/exit sequencer (exceptions, mret, MEI/MSI/MTI).
// Define TRAP_MTVAL_EN to add the mtval write state.
module rv_trap_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_exc_valid,
  input  logic [3:0]  i_exc_cause,
  input  logic [31:0] i_exc_pc,
  input  logic [31:0] i_exc_tval,
  input  logic        i_mret,
  input  logic        i_irq_ext,
  input  logic        i_irq_timer,
  input  logic        i_irq_soft,
  input  logic        i_mstatus_mie,
  input  logic [2:0]  i_mie,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  input  logic [31:0] i_int_pc,
  input  logic        i_flush_ack,
  input  logic        i_csr_busy,
  output logic        o_flush_req,
  output logic        o_csr_we,
  output logic [11:0] o_csr_idx,
  output logic [31:0] o_csr_wdata,
  output logic        o_status_trap,
  output logic        o_status_mret,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic [2:0]  o_mip,
  output logic        o_busy
);
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] DRAIN    = 4'd1;
  localparam logic [3:0] W_EPC    = 4'd2;
  localparam logic [3:0] W_CAUSE  = 4'd3;
  localparam logic [3:0] STATUS   = 4'd5;
  localparam logic [3:0] REDIRECT = 4'd6;
  localparam logic [3:0] M_DRAIN  = 4'd7;
  localparam logic [3:0] M_STATUS = 4'd8;
`ifdef TRAP_MTVAL_EN
  localparam logic [3:0] W_TVAL   = 4'd4;
  logic [31:0] tval;
`else
  logic unused_tval;
  assign unused_tval = ^i_exc_tval;
`endif
  logic [3:0]  state, state_n, code, irq_code;
  logic        intr, irq, wr_done, vec;
  logic [2:0]  pend;
  logic [31:0] epc, base, target;
  logic        unused_mepc;
  assign unused_mepc = i_mepc[0];
  assign pend = o_mip & i_mie & {3{i_mstatus_mie}};
  assign irq = |pend;
  // {MEIP, MTIP, MSIP}: external beats software beats timer
  assign irq_code = pend[2] ? 4'd11 : pend[0] ? 4'd3 : 4'd7;
  assign wr_done = o_csr_we && !i_csr_busy;
  assign base = {i_mtvec[31:2], 2'b00};
  assign vec = VECTORED_EN && i_mtvec[1:0] == 2'b01 && intr;
  assign target = (state == M_STATUS) ? {i_mepc[31:1], 1'b0} : base + (vec ? {26'b0, code, 2'b00} : 32'b0);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = i_exc_valid ? DRAIN : i_mret ? M_DRAIN : irq ? DRAIN : IDLE;
      DRAIN:    state_n = i_flush_ack ? W_EPC : DRAIN;
      W_EPC:    state_n = wr_done ? W_CAUSE : W_EPC;
`ifdef TRAP_MTVAL_EN
      W_CAUSE:  state_n = wr_done ? W_TVAL : W_CAUSE;
      W_TVAL:   state_n = wr_done ? STATUS : W_TVAL;
`else
      W_CAUSE:  state_n = wr_done ? STATUS : W_CAUSE;
`endif
      STATUS:   state_n = REDIRECT;
      M_DRAIN:  state_n = i_flush_ack ? M_STATUS : M_DRAIN;
      M_STATUS: state_n = REDIRECT;
      default:  state_n = IDLE;
    endcase
  end
  always_comb begin
    o_csr_we    = 1'b1;
    o_csr_idx   = 12'h000;
    o_csr_wdata = 32'h0;
    case (state)
      W_EPC:   begin o_csr_idx = 12'h341; o_csr_wdata = epc; end
      W_CAUSE: begin o_csr_idx = 12'h342; o_csr_wdata = {intr, 27'b0, code}; end
`ifdef TRAP_MTVAL_EN
      W_TVAL:  begin o_csr_idx = 12'h343; o_csr_wdata = tval; end
`endif
      default: o_csr_we = 1'b0;
    endcase
  end
  assign o_busy        = state != IDLE;
  assign o_flush_req   = state == DRAIN || state == M_DRAIN;
  assign o_status_trap = state == STATUS;
  assign o_status_mret = state == M_STATUS;
  assign o_redirect    = state == REDIRECT;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      o_mip         <= 3'b000;
      code          <= 4'd0;
      intr          <= 1'b0;
      epc           <= 32'h0;
      o_redirect_pc <= RESET_PC;
    end else begin
      state <= state_n;
      o_mip <= {i_irq_ext, i_irq_timer, i_irq_soft};
      if (state == IDLE && i_exc_valid) begin
        code <= i_exc_cause;
        intr <= 1'b0;
        epc  <= i_exc_pc;
      end else if (state == IDLE && !i_mret && irq) begin
        code <= irq_code;
        intr <= 1'b1;
      end
      // interrupts take the PC of the oldest unretired instruction once drained
      if (state == DRAIN && intr && i_flush_ack) epc <= i_int_pc;
      if (state_n == REDIRECT) o_redirect_pc <= target;
    end
  end
`ifdef TRAP_MTVAL_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) tval <= 32'h0;
    else if (state == IDLE && i_exc_valid) tval <= i_exc_tval;
    else if (state == IDLE && !i_mret && irq) tval <= 32'h0;
  end
`endif
endmodule
